// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b definitions for the encoder and decoder blocks.
// Holds the K28.5 comma patterns, the sync state type and the 6b->5b and
// 4b->3b table decoders. Sub-block codes are written MSB-first in
// transmission order: 6b = {a,b,c,d,e,i}, 4b = {f,g,h,j}. Decoded values are
// EDCBA (5b) and HGF (3b) with A/F in bit 0.
package enc8b10b_pkg;

  localparam logic [9:0] K28_5_RDN = 10'b001111_1010;
  localparam logic [9:0] K28_5_RDP = 10'b110000_0101;

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } sync_state_t;

  typedef struct packed {
    logic [4:0]        val;
    logic              ok;
    logic signed [3:0] disp;
    logic              is_k28;
  } dec6_t;

  typedef struct packed {
    logic [2:0]        val;
    logic              ok;
    logic signed [3:0] disp;
  } dec4_t;

  // Ones minus zeros over a 6-bit sub-block: -6..+6.
  function automatic logic signed [3:0] disp_of6(input logic [5:0] c);
    logic [2:0]        ones;
    logic signed [4:0] t;
    ones = 3'd0;
    for (int i = 0; i < 6; i++) ones = ones + {2'b00, c[i]};
    t = $signed({1'b0, ones, 1'b0}) - 5'sd6;
    return t[3:0];
  endfunction

  // Ones minus zeros over a 4-bit sub-block: -4..+4.
  function automatic logic signed [3:0] disp_of4(input logic [3:0] c);
    logic [2:0]        ones;
    logic signed [4:0] t;
    ones = 3'd0;
    for (int i = 0; i < 4; i++) ones = ones + {2'b00, c[i]};
    t = $signed({1'b0, ones, 1'b0}) - 5'sd4;
    return t[3:0];
  endfunction

  function automatic dec6_t dec_6b(input logic [5:0] c);
    dec6_t r;
    r.ok     = 1'b1;
    r.is_k28 = 1'b0;
    r.disp   = disp_of6(c);
    case (c)
      6'b100111, 6'b011000: r.val = 5'd0;
      6'b011101, 6'b100010: r.val = 5'd1;
      6'b101101, 6'b010010: r.val = 5'd2;
      6'b110001:            r.val = 5'd3;
      6'b110101, 6'b001010: r.val = 5'd4;
      6'b101001:            r.val = 5'd5;
      6'b011001:            r.val = 5'd6;
      6'b111000, 6'b000111: r.val = 5'd7;
      6'b111001, 6'b000110: r.val = 5'd8;
      6'b100101:            r.val = 5'd9;
      6'b010101:            r.val = 5'd10;
      6'b110100:            r.val = 5'd11;
      6'b001101:            r.val = 5'd12;
      6'b101100:            r.val = 5'd13;
      6'b011100:            r.val = 5'd14;
      6'b010111, 6'b101000: r.val = 5'd15;
      6'b011011, 6'b100100: r.val = 5'd16;
      6'b100011:            r.val = 5'd17;
      6'b010011:            r.val = 5'd18;
      6'b110010:            r.val = 5'd19;
      6'b001011:            r.val = 5'd20;
      6'b101010:            r.val = 5'd21;
      6'b011010:            r.val = 5'd22;
      6'b111010, 6'b000101: r.val = 5'd23;
      6'b110011, 6'b001100: r.val = 5'd24;
      6'b100110:            r.val = 5'd25;
      6'b010110:            r.val = 5'd26;
      6'b110110, 6'b001001: r.val = 5'd27;
      6'b001110:            r.val = 5'd28;
      6'b001111, 6'b110000: begin
        r.val    = 5'd28;
        r.is_k28 = 1'b1;
      end
      6'b101110, 6'b010001: r.val = 5'd29;
      6'b011110, 6'b100001: r.val = 5'd30;
      6'b101011, 6'b010100: r.val = 5'd31;
      default: begin
        r.val = 5'd0;
        r.ok  = 1'b0;
      end
    endcase
    return r;
  endfunction

  // Primary and alternate x.7 forms both decode to 7.
  function automatic dec4_t dec_4b(input logic [3:0] c);
    dec4_t r;
    r.ok   = 1'b1;
    r.disp = disp_of4(c);
    case (c)
      4'b1011, 4'b0100:                   r.val = 3'd0;
      4'b1001:                            r.val = 3'd1;
      4'b0101:                            r.val = 3'd2;
      4'b1100, 4'b0011:                   r.val = 3'd3;
      4'b1101, 4'b0010:                   r.val = 3'd4;
      4'b1010:                            r.val = 3'd5;
      4'b0110:                            r.val = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: r.val = 3'd7;
      default: begin
        r.val = 3'd0;
        r.ok  = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dec_8b10b_sync_fsm.sv
// Comma-based link synchronisation state machine.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   sym_valid       a decoded symbol is presented this cycle
//   sym_err         that symbol carries a code or disparity error
//   sym_comma       that symbol is K28.5
//   sync            registered: state is SYNC
//   state           registered current state
// The outputs update on the same edge that registers the decoded symbol, so
// sync changes together with valid_out for the transitioning symbol.
module dec_8b10b_sync_fsm
  import enc8b10b_pkg::*;
#(
  parameter int ACQ_COMMAS = 3,
  parameter int ERR_MAX    = 4,
  parameter int GOOD_RUN   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sym_valid,
  input  logic        sym_err,
  input  logic        sym_comma,
  output logic        sync,
  output sync_state_t state
);

  localparam int AW = $clog2(ACQ_COMMAS + 1);
  localparam int EW = $clog2(ERR_MAX + 1);
  localparam int GW = $clog2(GOOD_RUN + 1);
  localparam logic [AW-1:0] ACQ_LAST  = AW'(ACQ_COMMAS);
  localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_MAX);
  localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_RUN);

  logic [AW-1:0] acq_cnt;
  logic [EW-1:0] err_cnt;
  logic [GW-1:0] good_cnt;
  logic          clean_comma;

  assign clean_comma = sym_comma && !sym_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= LOS;
      sync     <= 1'b0;
      acq_cnt  <= '0;
      err_cnt  <= '0;
      good_cnt <= '0;
    end else if (sym_valid) begin
      case (state)
        LOS: begin
          if (clean_comma) begin
            if (ACQ_COMMAS <= 1) begin
              state    <= SYNC;
              sync     <= 1'b1;
              acq_cnt  <= '0;
              err_cnt  <= '0;
              good_cnt <= '0;
            end else begin
              state   <= ACQ;
              acq_cnt <= AW'(1);
            end
          end
        end
        ACQ: begin
          if (sym_err) begin
            state   <= LOS;
            acq_cnt <= '0;
          end else if (sym_comma) begin
            if (acq_cnt + 1'b1 == ACQ_LAST) begin
              state    <= SYNC;
              sync     <= 1'b1;
              acq_cnt  <= '0;
              err_cnt  <= '0;
              good_cnt <= '0;
            end else begin
              acq_cnt <= acq_cnt + 1'b1;
            end
          end
        end
        SYNC: begin
          if (sym_err) begin
            good_cnt <= '0;
            if (err_cnt + 1'b1 == ERR_LAST) begin
              state   <= LOS;
              sync    <= 1'b0;
              err_cnt <= '0;
            end else begin
              err_cnt <= err_cnt + 1'b1;
            end
          end else if (good_cnt + 1'b1 == GOOD_LAST) begin
            // A long enough clean run forgives earlier errors.
            good_cnt <= '0;
            err_cnt  <= '0;
          end else begin
            good_cnt <= good_cnt + 1'b1;
          end
        end
        default: begin
          state <= LOS;
          sync  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dec_8b10b.sv
// 8b/10b decoder with running-disparity tracking and comma sync.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   sym_in[9:0]     {a,b,c,d,e,i,f,g,h,j}, a = bit 9
//   sym_valid       sym_in valid this cycle
//   data_out[7:0]   HGFEDCBA, A = bit 0 (0x00 on code error)
//   k_out           control symbol
//   valid_out       sym_valid delayed one cycle
//   code_err        6b or 4b sub-block not in the tables
//   disp_err        sub-block disparity conflicts with running disparity
//   comma_out       symbol is K28.5
//   rd_out          running disparity (1 = RD+)
//   sync            sync FSM is in SYNC
// Optional (macro DEC_8B10B_STATS_EN):
//   stats_clr                    clear the error counters
//   code_err_cnt, disp_err_cnt   saturating 16-bit error counters
// Data outputs and flags hold their last value while valid_out is low.
module dec_8b10b
  import enc8b10b_pkg::*;
#(
  parameter int ACQ_COMMAS = 3,
  parameter int ERR_MAX    = 4,
  parameter int GOOD_RUN   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sym_in,
  input  logic       sym_valid,
  output logic [7:0] data_out,
  output logic       k_out,
  output logic       valid_out,
  output logic       code_err,
  output logic       disp_err,
  output logic       comma_out,
  output logic       rd_out,
  output logic       sync
`ifdef DEC_8B10B_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] code_err_cnt,
  output logic [15:0] disp_err_cnt
`endif
);

  logic [5:0]        c6;
  logic [3:0]        c4;
  dec6_t             d6;
  dec4_t             d4;
  logic              k28_rdp;
  logic signed [3:0] disp6;
  logic signed [3:0] disp4;
  logic              err6;
  logic              err4;
  logic              rd_mid;
  logic              rd_nxt;
  logic              k_alt;
  logic              code_err_c;
  logic              disp_err_c;
  logic              k_c;
  logic              comma_c;
  logic [7:0]        data_c;

  logic [7:0]        data_p1;
  logic              k_p1;
  logic              vld_p1;
  logic              code_err_p1;
  logic              disp_err_p1;
  logic              comma_p1;
  logic              rd_p1;
  logic              sync_p1;
  sync_state_t       fsm_state;

  assign c6 = sym_in[9:4];
  assign c4 = sym_in[3:0];

  // ---- stage p0: combinational decode against the current RD ----
  always_comb begin
    d6      = dec_6b(c6);
    // K28.y sent as 110000 carries its 4b sub-block complemented relative
    // to the data table, so decode the complement and negate its disparity.
    k28_rdp = (c6 == 6'b110000);
    d4      = dec_4b(k28_rdp ? ~c4 : c4);
    disp6   = d6.disp;
    disp4   = k28_rdp ? -d4.disp : d4.disp;

    err6 = ((disp6 > 4'sd0) &&  rd_p1) ||
           ((disp6 < 4'sd0) && !rd_p1) ||
           ((c6 == 6'b111000) &&  rd_p1) ||
           ((c6 == 6'b000111) && !rd_p1);
    if (disp6 != 4'sd0)                           rd_mid = (disp6 > 4'sd0);
    else if (c6 == 6'b111000 || c6 == 6'b000111)  rd_mid = ~rd_p1;
    else                                          rd_mid = rd_p1;

    err4 = ((disp4 > 4'sd0) &&  rd_mid) ||
           ((disp4 < 4'sd0) && !rd_mid) ||
           ((c4 == 4'b1100) &&  rd_mid) ||
           ((c4 == 4'b0011) && !rd_mid);
    if (disp4 != 4'sd0)                      rd_nxt = (disp4 > 4'sd0);
    else if (c4 == 4'b1100 || c4 == 4'b0011) rd_nxt = ~rd_mid;
    else                                     rd_nxt = rd_mid;

    // K23.7/K27.7/K29.7/K30.7 use the alternate x.7 4b sub-block.
    k_alt = (c4 == 4'b0111 || c4 == 4'b1000) &&
            (d6.val == 5'd23 || d6.val == 5'd27 ||
             d6.val == 5'd29 || d6.val == 5'd30);

    code_err_c = !d6.ok || !d4.ok;
    disp_err_c = err6 || err4;
    k_c        = !code_err_c && (d6.is_k28 || k_alt);
    data_c     = code_err_c ? 8'h00 : {d4.val, d6.val};
    comma_c    = k_c && (data_c == 8'hBC);
  end

  // ---- stage p1: registered outputs and running disparity ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      data_p1     <= 8'h00;
      k_p1        <= 1'b0;
      code_err_p1 <= 1'b0;
      disp_err_p1 <= 1'b0;
      comma_p1    <= 1'b0;
      rd_p1       <= 1'b0;
    end else begin
      vld_p1 <= sym_valid;
      if (sym_valid) begin
        data_p1     <= data_c;
        k_p1        <= k_c;
        code_err_p1 <= code_err_c;
        disp_err_p1 <= disp_err_c;
        comma_p1    <= comma_c;
        rd_p1       <= rd_nxt;
      end
    end
  end

  dec_8b10b_sync_fsm #(
    .ACQ_COMMAS (ACQ_COMMAS),
    .ERR_MAX    (ERR_MAX),
    .GOOD_RUN   (GOOD_RUN)
  ) u_sync_fsm (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .sym_err   (code_err_c || disp_err_c),
    .sym_comma (comma_c),
    .sync      (sync_p1),
    .state     (fsm_state)
  );

  // The FSM keeps sync and state in separate registers; they must agree.
  always_ff @(posedge clk) begin
    if (rst) assert (sync_p1 == (fsm_state == SYNC));
  end

  assign data_out  = data_p1;
  assign k_out     = k_p1;
  assign valid_out = vld_p1;
  assign code_err  = code_err_p1;
  assign disp_err  = disp_err_p1;
  assign comma_out = comma_p1;
  assign rd_out    = rd_p1;
  assign sync      = sync_p1;

`ifdef DEC_8B10B_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] code_cnt_p2;
  logic [15:0] disp_cnt_p2;

  // ---- stage p2: error statistics from the registered flags ----
  always_ff @(posedge clk) begin
    if (!rst || stats_clr) begin
      code_cnt_p2 <= 16'd0;
      disp_cnt_p2 <= 16'd0;
    end else begin
      if (vld_p1 && code_err_p1) code_cnt_p2 <= sat_inc16(code_cnt_p2);
      if (vld_p1 && disp_err_p1) disp_cnt_p2 <= sat_inc16(disp_cnt_p2);
    end
  end

  assign code_err_cnt = code_cnt_p2;
  assign disp_err_cnt = disp_cnt_p2;
`endif

endmodule

// File: tb/tb_dec_8b10b.sv
module tb_dec_8b10b;

  localparam logic [9:0] RDN   = 10'b001111_1010;
  localparam logic [9:0] RDP   = 10'b110000_0101;
  localparam logic [9:0] D0N   = 10'b100111_0100;
  localparam logic [9:0] D0P   = 10'b011000_1011;
  localparam logic [9:0] BAD   = 10'b111111_1111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] sym_in = 10'd0;
  logic       sym_valid = 1'b0;
  logic [7:0] data_out;
  logic       k_out, valid_out, code_err, disp_err, comma_out, rd_out, sync;
`ifdef DEC_8B10B_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] code_err_cnt, disp_err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // {valid, data, k, code_err, disp_err, comma, rd, sync}
  logic [14:0] obs;
  assign obs = {valid_out, data_out, k_out, code_err, disp_err, comma_out, rd_out, sync};

  dec_8b10b dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .data_out  (data_out),
    .k_out     (k_out),
    .valid_out (valid_out),
    .code_err  (code_err),
    .disp_err  (disp_err),
    .comma_out (comma_out),
    .rd_out    (rd_out),
    .sync      (sync)
`ifdef DEC_8B10B_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .code_err_cnt (code_err_cnt),
    .disp_err_cnt (disp_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic [9:0] s, input logic v);
    @(negedge clk);
    sym_in    = s;
    sym_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    sym_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h want %h", obs, 15'd0);
    end
  endtask

  task automatic test_d0();
    drive(D0N, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL d0_rdn got %h want %h", obs, {1'b1, 8'h00, 6'b000000});
    end
  endtask

  task automatic test_k28();
    drive(RDN, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL k28_5_first got %h want %h", obs, {1'b1, 8'hBC, 6'b100110});
    end
    drive(RDN, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL k28_5_repeat_disp got %h want %h", obs, {1'b1, 8'hBC, 6'b101110});
    end
  endtask

  task automatic test_alt_commas();
    do_reset();
    drive(RDN, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 8'hBC, 6'b100110}) begin
      n_bad++;
      $display("FAIL acq_comma1 got %h want %h", obs, {1'b1, 8'hBC, 6'b100110});
    end
    drive(RDP, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 8'hBC, 6'b100100}) begin
      n_bad++;
      $display("FAIL acq_comma2 got %h want %h", obs, {1'b1, 8'hBC, 6'b100100});
    end
    drive(RDN, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 8'hBC, 6'b100111}) begin
      n_bad++;
      $display("FAIL acq_comma3_sync got %h want %h", obs, {1'b1, 8'hBC, 6'b100111});
    end
  endtask

  // Entered in SYNC with RD+.
  task automatic test_code_err();
    for (int i = 0; i < 4; i++) begin
      drive(BAD, 1'b1);
      n_cmp++;
      if (obs !== {1'b1, 8'h00, 5'b01101, (i < 3)}) begin
        n_bad++;
        $display("FAIL code_err_%0d got %h want %h", i, obs, {1'b1, 8'h00, 5'b01101, (i < 3)});
      end
      if (i < 3) begin
        drive(RDP, 1'b1);
        n_cmp++;
        if (obs !== {1'b1, 8'hBC, 6'b100101}) begin
          n_bad++;
          $display("FAIL code_err_gap_%0d got %h want %h", i, obs, {1'b1, 8'hBC, 6'b100101});
        end
      end
    end
  endtask

  task automatic test_good_run();
    do_reset();
    drive(RDN, 1'b1);
    drive(RDP, 1'b1);
    drive(RDN, 1'b1);
    for (int i = 0; i < 3; i++) drive(BAD, 1'b1);
    n_cmp++;
    if (sync !== 1'b1) begin
      n_bad++;
      $display("FAIL good_run_three_errs sync got %b want 1", sync);
    end
    for (int i = 0; i < 16; i++) drive((i % 2 == 0) ? RDP : RDN, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 8'hBC, 6'b100111}) begin
      n_bad++;
      $display("FAIL good_run_clean got %h want %h", obs, {1'b1, 8'hBC, 6'b100111});
    end
    for (int i = 0; i < 3; i++) drive(BAD, 1'b1);
    n_cmp++;
    if (sync !== 1'b1) begin
      n_bad++;
      $display("FAIL good_run_cleared sync got %b want 1", sync);
    end
    drive(BAD, 1'b1);
    n_cmp++;
    if (sync !== 1'b0) begin
      n_bad++;
      $display("FAIL good_run_fourth sync got %b want 0", sync);
    end
  endtask

  task automatic test_k_codes();
    logic [9:0]  syms [4];
    logic [14:0] exp  [4];
    syms[0] = 10'b111010_1000; exp[0] = {1'b1, 8'hF7, 6'b100000};
    syms[1] = 10'b001111_1001; exp[1] = {1'b1, 8'h3C, 6'b100010};
    syms[2] = 10'b110000_0111; exp[2] = {1'b1, 8'hFC, 6'b100010};
    syms[3] = 10'b110100_1000; exp[3] = {1'b1, 8'hEB, 6'b000000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(syms[i], 1'b1);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL k_code_%0d got %h want %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_gap();
    do_reset();
    drive(RDN, 1'b1);
    drive(D0P, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 8'h00, 6'b000010}) begin
      n_bad++;
      $display("FAIL gap_d0_first got %h want %h", obs, {1'b1, 8'h00, 6'b000010});
    end
    for (int i = 0; i < 5; i++) begin
      drive(BAD, 1'b0);
      n_cmp++;
      if (obs !== {1'b0, 8'h00, 6'b000010}) begin
        n_bad++;
        $display("FAIL gap_idle_%0d got %h want %h", i, obs, {1'b0, 8'h00, 6'b000010});
      end
    end
    drive(D0P, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 8'h00, 6'b000010}) begin
      n_bad++;
      $display("FAIL gap_d0_second got %h want %h", obs, {1'b1, 8'h00, 6'b000010});
    end
    drive(RDP, 1'b1);
    drive(RDN, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 8'hBC, 6'b100111}) begin
      n_bad++;
      $display("FAIL gap_acq_held got %h want %h", obs, {1'b1, 8'hBC, 6'b100111});
    end
  endtask

  // Entered in SYNC with RD+.
  task automatic test_reset_mid();
    @(negedge clk);
    rst       = 1'b0;
    sym_in    = RDP;
    sym_valid = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs got %h want %h", obs, 15'd0);
    end
    @(negedge clk);
    rst       = 1'b1;
    sym_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_mid_dropped got %h want %h", obs, 15'd0);
    end
    drive(RDP, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 8'hBC, 6'b101100}) begin
      n_bad++;
      $display("FAIL reset_mid_rd_minus got %h want %h", obs, {1'b1, 8'hBC, 6'b101100});
    end
  endtask

`ifdef DEC_8B10B_STATS_EN
  task automatic test_stats();
    do_reset();
    drive(RDN, 1'b1);
    for (int i = 0; i < 3; i++) drive(RDN, 1'b1);
    drive(RDN, 1'b0);
    n_cmp++;
    if (disp_err_cnt !== 16'd3 || code_err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL stats_count got disp=%0d code=%0d want disp=3 code=0", disp_err_cnt, code_err_cnt);
    end
    @(negedge clk);
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    n_cmp++;
    if (disp_err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL stats_clear got %0d want 0", disp_err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_d0();
    test_k28();
    test_alt_commas();
    test_code_err();
    test_good_run();
    test_k_codes();
    test_gap();
    test_reset_mid();
`ifdef DEC_8B10B_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
